// File: rtl/mem_access_ctrl.sv
// Memory-access controller behind the IorD mux: word/half/byte loads and stores against a
// word-wide memory, with read-modify-write for sub-word stores and misalignment faulting.
module mem_access_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a level sampled only while idle; done is a one-cycle pulse, and
  // misalign/rdata are meaningful in the done cycle (rdata then holds until the next load).
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_lane;
  logic [1:0]     r_size;
  logic           r_write;
  logic           r_sext;
  logic           r_fault;
  logic [15:0]    r_wdata;
  logic [31:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic [31:0]    r_rdata;
  logic [CW-1:0]  r_cnt;

  logic           w_word;
  logic           w_fault;
  logic           w_accept;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_merged;
  logic [31:0]    w_loaded;

  // Reserved size encoding behaves as a word access.
  assign w_word   = (size != 2'b01) && (size != 2'b10);
  assign w_fault  = (w_word && (addr[1:0] != 2'b00)) || ((size == 2'b01) && addr[0]);
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_fault)                w_next = S_DONE;
          else if (op_write && w_word) w_next = S_WR;
          else                        w_next = S_RD;
        end
      end
      S_RD:    if (r_cnt == '0) w_next = r_write ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for read-modify-write stores.
  always_comb begin
    w_byte   = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half   = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    w_merged = mem_rdata;
    w_loaded = mem_rdata;
    case (r_size)
      2'b10: begin
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        w_loaded = {{24{r_sext & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        w_loaded = {{16{r_sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane      <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
      r_sext      <= 1'b0;
      r_fault     <= 1'b0;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_lane     <= addr[1:0];
      r_size     <= size;
      r_write    <= op_write;
      r_sext     <= sign_ext;
      r_fault    <= w_fault;
      r_wdata    <= wdata[15:0];
      r_mem_addr <= {addr[31:2], 2'b00};
      r_cnt      <= CNT_INIT;
      if (op_write && w_word && !w_fault) r_mem_wdata <= wdata;
    end else if (r_state == S_RD) begin
      if (r_cnt == '0) begin
        if (r_write) r_mem_wdata <= w_merged;
        else         r_rdata     <= w_loaded;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign misalign  = (r_state == S_DONE) && r_fault;
  assign mem_we    = (r_state == S_WR);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT 1 and 3) share stimulus and are checked
// every cycle against a transaction-level model; directed cases pin exact literal results.
module tb_mem_access_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op_write = 1'b0;
  logic        sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [1:0]  d_busy, d_done, d_mis, d_we;
  logic [31:0] d_rdata [2];
  logic [31:0] d_maddr [2];
  logic [31:0] d_mwdata [2];
  logic [31:0] d_mrdata [2];
  logic [1:0]  d_state [2];

  logic [31:0] mem [2][16];
  logic [31:0] exp_mem [2][16];

  // Model: m_cyc = cycle number within the current transaction (0 = idle).
  int          m_cyc [2];
  int          m_lat [2];
  bit          m_fault [2];
  bit          m_write [2];
  logic [31:0] m_maddr [2];
  logic [31:0] m_wword [2];
  logic [31:0] m_load [2];
  logic [31:0] m_rdata [2];

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] mw;
  bit          wordsz;
  int          lat_p;
  bit          hold;
  logic [31:0] saved0, saved1;
  int          dcnt0, dcnt1;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .op_write(op_write), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(d_busy[0]), .done(d_done[0]),
    .misalign(d_mis[0]), .rdata(d_rdata[0]), .mem_addr(d_maddr[0]), .mem_we(d_we[0]),
    .mem_wdata(d_mwdata[0]), .mem_rdata(d_mrdata[0]), .dbg_state(d_state[0])
  );

  mem_access_ctrl #(.MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op_write(op_write), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(d_busy[1]), .done(d_done[1]),
    .misalign(d_mis[1]), .rdata(d_rdata[1]), .mem_addr(d_maddr[1]), .mem_we(d_we[1]),
    .mem_wdata(d_mwdata[1]), .mem_rdata(d_mrdata[1]), .dbg_state(d_state[1])
  );

  assign d_mrdata[0] = mem[0][d_maddr[0][5:2]];
  assign d_mrdata[1] = mem[1][d_maddr[1][5:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (d_we[i]) mem[i][d_maddr[i][5:2]] <= d_mwdata[i];
  end

  function automatic logic [31:0] f_load(logic [31:0] w, logic [1:0] sz, logic [1:0] lo, bit sx);
    logic [31:0] v;
    if (sz == 2'd2) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_store(logic [31:0] w, logic [1:0] sz, logic [1:0] lo,
                                          logic [31:0] wd);
    int sh;
    if (sz == 2'd2) begin
      sh = 8 * lo;
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = 16 * lo[1];
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, i, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input int i);
    chk(i, "rst_busy", d_busy[i], 0);
    chk(i, "rst_done", d_done[i], 0);
    chk(i, "rst_misalign", d_mis[i], 0);
    chk(i, "rst_mem_we", d_we[i], 0);
    chk(i, "rst_rdata", d_rdata[i], 0);
    chk(i, "rst_mem_addr", d_maddr[i], 0);
    chk(i, "rst_mem_wdata", d_mwdata[i], 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i]   = 0;
      m_rdata[i] = '0;
    end
  endtask

  // Transaction model: advances once per rising edge while out of reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        lat_p = (i == 0) ? LAT0 : LAT1;
        if (m_cyc[i] == 0) begin
          if (start) begin
            mw          = exp_mem[i][addr[5:2]];
            wordsz      = (size == 2'd0) || (size == 2'd3);
            m_fault[i]  = (wordsz && addr[1:0] != 2'd0) || (size == 2'd1 && addr[0]);
            m_write[i]  = op_write;
            m_maddr[i]  = {addr[31:2], 2'b00};
            m_wword[i]  = f_store(mw, size, addr[1:0], wdata);
            m_load[i]   = f_load(mw, size, addr[1:0], sign_ext);
            m_lat[i]    = m_fault[i] ? 1 : (!op_write ? lat_p + 1 : (wordsz ? 2 : lat_p + 2));
            m_cyc[i]    = 1;
          end
        end else begin
          if (m_cyc[i] == m_lat[i] - 1 && m_write[i] && !m_fault[i])
            exp_mem[i][m_maddr[i][5:2]] = m_wword[i];
          if (m_cyc[i] == m_lat[i]) begin
            m_cyc[i] = 0;
          end else begin
            m_cyc[i]++;
            if (m_cyc[i] == m_lat[i] && !m_write[i] && !m_fault[i]) m_rdata[i] = m_load[i];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "busy", d_busy[i], m_cyc[i] != 0);
        chk(i, "done", d_done[i], m_cyc[i] != 0 && m_cyc[i] == m_lat[i]);
        chk(i, "misalign", d_mis[i], m_cyc[i] != 0 && m_cyc[i] == m_lat[i] && m_fault[i]);
        chk(i, "mem_we", d_we[i],
            m_cyc[i] != 0 && m_write[i] && !m_fault[i] && m_cyc[i] == m_lat[i] - 1);
        chk(i, "rdata", d_rdata[i], m_rdata[i]);
        if (m_cyc[i] != 0) chk(i, "mem_addr", d_maddr[i], m_maddr[i]);
        if (m_cyc[i] != 0 && m_write[i] && !m_fault[i] && m_cyc[i] == m_lat[i] - 1)
          chk(i, "mem_wdata", d_mwdata[i], m_wword[i]);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_busy == 2'b00 && m_cyc[0] == 0 && m_cyc[1] == 0) break;
    end
    chk(0, "idle_timeout", {30'b0, d_busy}, 0);
    #1;
  endtask

  // Issues one request from negedge+1 and measures instance 0 against literal expectations.
  task automatic run_op(input bit wr, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat, input int exp_we,
                        input bit exp_mis);
    int lat = 0;
    int we = 0;
    logic mis = 1'b0;
    logic [31:0] ma = '0;
    op_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_we[0]) we++;
      if (d_done[0]) begin
        lat = c; mis = d_mis[0]; ma = d_maddr[0];
      end
      #1 start = 1'b0;
      if (lat != 0) break;
    end
    chk(0, "latency", lat, exp_lat);
    chk(0, "we_cycles", we, exp_we);
    chk(0, "done_misalign", mis, exp_mis);
    chk(0, "done_mem_addr", ma, {a[31:2], 2'b00});
    wait_idle();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) begin
        mw = $urandom;
        mem[i][j] = mw;
        exp_mem[i][j] = mw;
      end
    for (int i = 0; i < 2; i++) begin
      mem[i][0] = 32'h8899_AABB;
      exp_mem[i][0] = 32'h8899_AABB;
    end

    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    #1 reset = 1'b1;

    // Byte loads, sign- and zero-extended.
    run_op(1'b0, 2'd2, 1'b1, 32'h0000_0101, 32'h0, 2, 0, 1'b0);
    chk(0, "ldb_sext", d_rdata[0], 32'hFFFF_FFAA);
    chk(0, "model_ldb_sext", m_rdata[0], 32'hFFFF_FFAA);
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 2, 0, 1'b0);
    chk(0, "ldb_zext", d_rdata[0], 32'h0000_00AA);

    // Byte store via read-modify-write.
    run_op(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h0000_0011, 3, 1, 1'b0);
    chk(0, "stb_mem", mem[0][0], 32'h8811_AABB);
    chk(0, "model_stb_mem", exp_mem[0][0], 32'h8811_AABB);
    chk(0, "stb_rdata_held", d_rdata[0], 32'h0000_00AA);

    // Word store then word load.
    run_op(1'b1, 2'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1, 1'b0);
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0, 2, 0, 1'b0);
    chk(0, "ldw", d_rdata[0], 32'hDEAD_BEEF);
    chk(1, "ldw_lat3", d_rdata[1], 32'hDEAD_BEEF);

    // Misaligned halfword load.
    run_op(1'b0, 2'd1, 1'b1, 32'h0000_0103, 32'h0, 1, 0, 1'b1);
    chk(0, "fault_rdata_held", d_rdata[0], 32'hDEAD_BEEF);

    // Reset asserted during the write cycle of a byte store.
    saved0 = mem[0][1];
    saved1 = mem[1][1];
    op_write = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h0000_0105; wdata = 32'h5A;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk(0, "we_before_rst", d_we[0], 1);
    #1 reset = 1'b0;
    model_reset();
    #1 chk_zero(0);
    chk_zero(1);
    @(negedge clk);
    #1 reset = 1'b1;
    chk(0, "rst_mem_kept", mem[0][1], saved0);
    chk(1, "rst_mem_kept", mem[1][1], saved1);
    chk(0, "model_rst_mem", exp_mem[0][1], saved0);

    // start held high: each instance re-accepts in the idle cycle after done.
    dcnt0 = 0; dcnt1 = 0;
    op_write = 1'b0; size = 2'd0; addr = 32'h0000_0100; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (d_done[0]) dcnt0++;
      if (d_done[1]) dcnt1++;
    end
    #1 start = 1'b0;
    chk(0, "held_start_dones", dcnt0, 4);
    chk(1, "held_start_dones", dcnt1, 2);
    wait_idle();

    // Randomized traffic with a held-start window and one mid-run reset.
    for (int k = 0; k < 700; k++) begin
      hold = (k >= 200 && k < 300);
      start    = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      op_write = 1'($urandom_range(0, 1));
      size     = 2'($urandom_range(0, 3));
      sign_ext = 1'($urandom_range(0, 1));
      addr     = $urandom;
      wdata    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1)      addr[0] = 1'b0;
        else if (size != 2'd2) addr[1:0] = 2'b00;
      end
      if (k == 450) begin
        reset = 1'b0;
        model_reset();
        #1 chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        #1 reset = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        chk(i, "final_mem", mem[i][j], exp_mem[i][j]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
